conv_accumulator_27: RTL and testbench

- Consumer end of the 27-lane fixed-point multiplier bank.
- Takes the packed 27 products, one 3x3x3 kernel window per valid, and sums them in a pipelined 3-level adder tree.
- Accumulates across a programmable number of windows (channel groups), then adds bias, applies optional ReLU and saturates to a bitsize-wide output pixel.
- Sits between the multiplier bank and the output feature-map writer.

---
 rtl/conv_accumulator_27.sv | 190 +++++++++++++++++++
 tb/tb_conv_accumulator_27.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/conv_accumulator_27.sv
// Accumulates 27-lane kernel-window products over a programmable number of channel
// groups, then adds bias, optionally applies ReLU and saturates to a pixel.
module conv_accumulator_27 #(
    parameter int bitsize   = 14,
    parameter int FRAC_BITS = 7,
    parameter int PROD_W    = 2*bitsize - FRAC_BITS,
    parameter int ACC_W     = PROD_W + 13
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_flag,
    input  logic [7:0]                group_count,
    input  logic signed [bitsize-1:0] bias,
    input  logic                      relu_en,
    input  logic [PROD_W*27-1:0]      Mul_result,
    input  logic                      valid,
    output logic signed [bitsize-1:0] result,
    output logic                      result_valid,
    output logic                      sat_flag,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic signed [ACC_W-1:0] PIX_MAX_S =
        {{(ACC_W-bitsize+1){1'b0}}, {(bitsize-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] PIX_MIN_S =
        {{(ACC_W-bitsize+1){1'b1}}, {(bitsize-1){1'b0}}};

    state_t                      state_r, state_nxt_s;
    logic [7:0]                  gc_r, in_cnt_r, out_cnt_r;
    logic signed [bitsize-1:0]   bias_r;
    logic                        relu_r;
    logic signed [ACC_W-1:0]     acc_r;
    logic signed [ACC_W-1:0]     lane_s [27];
    logic signed [ACC_W-1:0]     s1_r [9];
    logic signed [ACC_W-1:0]     s2_r [3];
    logic signed [ACC_W-1:0]     s3_r;
    logic                        v1_r, v2_r, v3_r;
    logic                        accept_s, start_ok_s, acc_done_s;
    logic signed [ACC_W-1:0]     sum_s;
    logic [bitsize:0]            sat_s;
    logic signed [bitsize-1:0]   result_r;
    logic                        result_valid_r, sat_r, busy_r;

    function automatic logic signed [ACC_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
        return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    // Returns {clip_flag, pixel}: ReLU clamp first, then two-sided saturation.
    function automatic logic [bitsize:0] saturate(input logic signed [ACC_W-1:0] s,
                                                  input logic relu);
        logic [bitsize:0] r;
        if (relu && s[ACC_W-1]) begin
            r = {1'b1, {bitsize{1'b0}}};
        end else if (s > PIX_MAX_S) begin
            r = {1'b1, 1'b0, {(bitsize-1){1'b1}}};
        end else if (s < PIX_MIN_S) begin
            r = {1'b1, 1'b1, {(bitsize-1){1'b0}}};
        end else begin
            r = {1'b0, s[bitsize-1:0]};
        end
        return r;
    endfunction

    // Lane unpacking and control qualifiers.
    always_comb begin
        for (int i = 0; i < 27; i++) begin
            lane_s[i] = sext_prod(Mul_result[i*PROD_W +: PROD_W]);
        end
        start_ok_s = (state_r == IDLE) && start_flag;
        accept_s   = (state_r == ACCUM) && valid && (in_cnt_r < gc_r);
        acc_done_s = (state_r == ACCUM) && v3_r && ((out_cnt_r + 8'd1) == gc_r);
        sum_s      = acc_r + {{(ACC_W-bitsize){bias_r[bitsize-1]}}, bias_r};
        sat_s      = saturate(sum_s, relu_r);
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_flag) begin
                    state_nxt_s = ACCUM;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCUM: begin
                if (acc_done_s) begin
                    state_nxt_s = FINISH;
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            FINISH:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Pipelined 3-level adder tree, each stage with its own valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r <= 1'b0;
            v2_r <= 1'b0;
            v3_r <= 1'b0;
            s3_r <= {ACC_W{1'b0}};
            for (int k = 0; k < 9; k++) s1_r[k] <= {ACC_W{1'b0}};
            for (int k = 0; k < 3; k++) s2_r[k] <= {ACC_W{1'b0}};
        end else begin
            v1_r <= accept_s;
            v2_r <= v1_r;
            v3_r <= v2_r;
            for (int k = 0; k < 9; k++) begin
                s1_r[k] <= lane_s[3*k] + lane_s[3*k+1] + lane_s[3*k+2];
            end
            for (int k = 0; k < 3; k++) begin
                s2_r[k] <= s1_r[3*k] + s1_r[3*k+1] + s1_r[3*k+2];
            end
            s3_r <= s2_r[0] + s2_r[1] + s2_r[2];
        end
    end

    // Per-pixel configuration, input/output window counters and accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            gc_r      <= 8'd1;
            bias_r    <= {bitsize{1'b0}};
            relu_r    <= 1'b0;
            acc_r     <= {ACC_W{1'b0}};
            in_cnt_r  <= 8'd0;
            out_cnt_r <= 8'd0;
        end else if (start_ok_s) begin
            gc_r      <= (group_count == 8'd0) ? 8'd1 : group_count;
            bias_r    <= bias;
            relu_r    <= relu_en;
            acc_r     <= {ACC_W{1'b0}};
            in_cnt_r  <= 8'd0;
            out_cnt_r <= 8'd0;
        end else begin
            if (accept_s) begin
                in_cnt_r <= in_cnt_r + 8'd1;
            end
            if ((state_r == ACCUM) && v3_r) begin
                acc_r     <= acc_r + s3_r;
                out_cnt_r <= out_cnt_r + 8'd1;
            end
        end
    end

    // Registered outputs; sat_flag only ever accompanies result_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r       <= {bitsize{1'b0}};
            result_valid_r <= 1'b0;
            sat_r          <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            result_valid_r <= 1'b0;
            sat_r          <= 1'b0;
            if (state_r == FINISH) begin
                result_r       <= sat_s[bitsize-1:0];
                result_valid_r <= 1'b1;
                sat_r          <= sat_s[bitsize];
                busy_r         <= 1'b0;
            end else if (start_ok_s) begin
                busy_r <= 1'b1;
            end
        end
    end

    assign result       = result_r;
    assign result_valid = result_valid_r;
    assign sat_flag     = sat_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_conv_accumulator_27.sv
// Directed bench for conv_accumulator_27 with hand-computed expected pixels.
module tb_conv_accumulator_27;

    localparam int BW = 14;
    localparam int PW = 21;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start_flag;
    logic [7:0]            group_count;
    logic signed [BW-1:0]  bias;
    logic                  relu_en;
    logic [PW*27-1:0]      Mul_result;
    logic                  valid;
    logic signed [BW-1:0]  result;
    logic                  result_valid;
    logic                  sat_flag;
    logic                  busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    int rv_seen;

    conv_accumulator_27 dut (
        .clk          (clk),
        .rst          (rst),
        .start_flag   (start_flag),
        .group_count  (group_count),
        .bias         (bias),
        .relu_en      (relu_en),
        .Mul_result   (Mul_result),
        .valid        (valid),
        .result       (result),
        .result_valid (result_valid),
        .sat_flag     (sat_flag),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_lanes(input int v);
        for (int i = 0; i < 27; i++) Mul_result[i*PW +: PW] = v[PW-1:0];
    endtask

    task automatic start_px(input int gc, input int b, input logic r);
        group_count = gc[7:0];
        bias        = b[BW-1:0];
        relu_en     = r;
        start_flag  = 1'b1;
        tick();
        start_flag  = 1'b0;
    endtask

    task automatic send_window(input int v);
        set_lanes(v);
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    // Ticks until result_valid, bounded; returns cycles taken (20 on timeout).
    task automatic wait_rv(output int c);
        c = 0;
        do begin
            tick();
            c++;
        end while (!result_valid && c < 20);
    endtask

    // Single-window pixel: start, one valid, wait, check value/flag/latency.
    task automatic one_window(input string tag, input int v, input int b, input logic r,
                              input int exp_res, input int exp_sat);
        start_px(1, b, r);
        send_window(v);
        wait_rv(cyc);
        check({tag, "_lat"}, cyc, 4);
        check({tag, "_res"}, result, exp_res);
        check({tag, "_sat"}, {31'd0, sat_flag}, exp_sat);
    endtask

    initial begin
        rst = 1'b1; start_flag = 1'b0; group_count = 8'd0; bias = '0;
        relu_en = 1'b0; valid = 1'b0; Mul_result = '0;
        tick(); tick(); tick();
        rst = 1'b0;
        check("rst_result", result, 0);
        check("rst_rv", {31'd0, result_valid}, 0);
        check("rst_sat", {31'd0, sat_flag}, 0);
        check("rst_busy", {31'd0, busy}, 0);

        // A valid while IDLE must not leak into the next pixel.
        send_window(1000);

        // Basic window: 27 * 128 = 3456, exact latency of 4 edges after the valid.
        start_px(1, 0, 1'b0);
        check("basic_busy", {31'd0, busy}, 1);
        send_window(128);
        tick(); tick(); tick();
        check("basic_rv_e3", {31'd0, result_valid}, 0);
        check("basic_busy_e3", {31'd0, busy}, 1);
        tick();
        check("basic_rv_e4", {31'd0, result_valid}, 1);
        check("basic_res", result, 3456);
        check("basic_sat", {31'd0, sat_flag}, 0);
        check("basic_busy_e4", {31'd0, busy}, 0);
        tick();
        check("basic_rv_e5", {31'd0, result_valid}, 0);
        check("basic_hold", result, 3456);

        // Multi-group back-to-back: 3*1728 + 128 = 5312; 4th valid and a mid-ACCUM start ignored.
        start_px(3, 128, 1'b0);
        set_lanes(64);
        valid = 1'b1;
        tick();
        start_flag = 1'b1;
        tick();
        start_flag = 1'b0;
        tick();
        check("multi_busy", {31'd0, busy}, 1);
        set_lanes(500);
        tick();
        valid = 1'b0;
        wait_rv(cyc);
        check("multi_lat", cyc, 3);
        check("multi_res", result, 5312);
        check("multi_sat", {31'd0, sat_flag}, 0);

        // Start accepted in the same cycle as result_valid.
        start_px(1, 0, 1'b0);
        check("b2b_busy", {31'd0, busy}, 1);
        send_window(1000);
        wait_rv(cyc);
        check("satpos_lat", cyc, 4);
        check("satpos_res", result, 8191);
        check("satpos_sat", {31'd0, sat_flag}, 1);
        tick();
        check("sat_clear", {31'd0, sat_flag}, 0);

        one_window("satneg", -1000, 0, 1'b0, -8192, 1);
        one_window("relu_off", -200, 0, 1'b0, -5400, 0);
        one_window("relu_on", -200, 0, 1'b1, 0, 1);

        // group_count = 0 behaves as 1: 27 * 10 + 5 = 275.
        start_px(0, 5, 1'b0);
        send_window(10);
        wait_rv(cyc);
        check("gc0_lat", cyc, 4);
        check("gc0_res", result, 275);

        // Reset after 1 of 3 windows aborts silently.
        start_px(3, 0, 1'b0);
        send_window(100);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_res", result, 0);
        rv_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (result_valid) rv_seen++;
        end
        check("abort_no_rv", rv_seen, 0);

        // Fresh start after abort: 2 * 27 * 3 = 162, no residue from the 2700 window.
        start_px(2, 0, 1'b0);
        send_window(3);
        send_window(3);
        wait_rv(cyc);
        check("fresh_lat", cyc, 4);
        check("fresh_res", result, 162);
        check("fresh_sat", {31'd0, sat_flag}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
